// File: rtl/is_uart_tx_sched.sv
// is_uart_tx_sched: round-robin scheduler that lets N_REQ byte sources
// share one UART transmitter, granting bursts of up to MAX_BURST bytes.
//
// Ports:
//   clk_i       clock
//   rst_i       asynchronous active-low reset
//   req_i       per-requester byte available
//   data_i      per-requester byte, requester k at [k*DATA_W +: DATA_W]
//   last_i      per-requester last-byte-of-packet flag
//   ack_o       one-cycle pulse: owner's byte consumed
//   gnt_o       one-hot current owner, zero when free
//   tx_start_o  one-cycle frame start to the transmitter
//   tx_data_o   registered byte to transmit
//   tx_busy_i   transmitter is shifting a frame
//   tx_done_i   one-cycle pulse: frame complete
//   busy_o      scheduler is not idle
module is_uart_tx_sched #(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [N_REQ-1:0]        req_i,
    input  logic [N_REQ*DATA_W-1:0] data_i,
    input  logic [N_REQ-1:0]        last_i,
    output logic [N_REQ-1:0]        ack_o,
    output logic [N_REQ-1:0]        gnt_o,
    output logic                    tx_start_o,
    output logic [DATA_W-1:0]       tx_data_o,
    input  logic                    tx_busy_i,
    input  logic                    tx_done_i,
    output logic                    busy_o
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    localparam logic [IDX_W:0]   N_EXT    = (IDX_W + 1)'(N_REQ);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_BURST);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        WAIT_DONE = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    owner_q, owner_d;
    logic [N_REQ-1:0]    gnt_q, gnt_d;
    logic [IDX_W-1:0]    rr_q, rr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                last_q, last_d;
    logic [DATA_W-1:0]   tx_data_q, tx_data_d;
    logic                tx_start_q, tx_start_d;
    logic [N_REQ-1:0]    ack_q, ack_d;

    logic [DATA_W-1:0]   data_arr [N_REQ];
    logic                pick_vld;
    logic [IDX_W-1:0]    pick_idx;
    logic                owner_req;
    logic                owner_last;
    logic [DATA_W-1:0]   owner_data;
    logic [IDX_W-1:0]    owner_nxt;

    for (genvar k = 0; k < N_REQ; k++) begin : g_lane
        assign data_arr[k] = data_i[k*DATA_W +: DATA_W];
    end

    assign owner_req  = req_i[owner_q];
    assign owner_last = last_i[owner_q];
    assign owner_data = data_arr[owner_q];
    assign owner_nxt  = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;

    // Rotating priority search starting at rr_q, wrapping modulo N_REQ.
    always_comb begin
        logic [IDX_W:0] cand;
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = {1'b0, rr_q} + (IDX_W + 1)'(i);
            if (cand >= N_EXT) begin
                cand = cand - N_EXT;
            end
            if (!pick_vld && req_i[cand[IDX_W-1:0]]) begin
                pick_vld = 1'b1;
                pick_idx = cand[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        gnt_d      = gnt_q;
        rr_d       = rr_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        ack_d      = '0;

        case (state_q)
            IDLE: begin
                gnt_d = '0;
                if (pick_vld) begin
                    owner_d         = pick_idx;
                    gnt_d[pick_idx] = 1'b1;
                    cnt_d           = '0;
                    state_d         = LOAD;
                end
            end

            LOAD: begin
                if (!owner_req) begin
                    // Owner withdrew before sending: hand the line on.
                    gnt_d   = '0;
                    rr_d    = owner_nxt;
                    state_d = IDLE;
                end else if (!tx_busy_i) begin
                    tx_start_d     = 1'b1;
                    tx_data_d      = owner_data;
                    ack_d[owner_q] = 1'b1;
                    last_d         = owner_last;
                    if (cnt_q != MAX_CNT) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    state_d = WAIT_DONE;
                end
            end

            WAIT_DONE: begin
                if (tx_done_i) begin
                    if (last_q || (cnt_q == MAX_CNT) || !owner_req) begin
                        gnt_d   = '0;
                        rr_d    = owner_nxt;
                        state_d = IDLE;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end

            default: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            gnt_q      <= '0;
            rr_q       <= '0;
            cnt_q      <= '0;
            last_q     <= 1'b0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            ack_q      <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            gnt_q      <= gnt_d;
            rr_q       <= rr_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            ack_q      <= ack_d;
        end
    end

    assign gnt_o      = gnt_q;
    assign ack_o      = ack_q;
    assign tx_start_o = tx_start_q;
    assign tx_data_o  = tx_data_q;
    assign busy_o     = (state_q != IDLE);

endmodule
